sprite_line_engine: RTL and testbench
=====================================

# sprite_line_engine

Parametrised successor of the line-buffered sprite engine: per scanline it scans a host-writable attribute RAM for sprites intersecting the next visible line, collects up to MAX_SLOT hits, then streams their pattern pixels into the line buffer. It adds configurable sprite size, vertical flip, transparency, horizontal clipping, a sticky overflow flag, and live attribute writes. It sits between the host register interface and the line-buffer write port, fed by an external 1-cycle-latency pattern ROM.

## Interface
- NUM_SPRITE, 32: attribute entries; power of two.
- MAX_SLOT, 8: max sprites drawn per line.
- SPR_W, 16: sprite width in pixels; power of two.
- SPR_H, 16: sprite height in pixels; power of two.
- H_ACTIVE, 640: visible columns.
- V_ACTIVE, 480: visible rows.
- V_TOTAL, 525: total rows per frame.
- TRANSPARENT, 16'h0000: pixel value that is never written.
- clk  in  1  single clock.
- reset  in  1  synchronous, active-low (0 = reset).
- line_start  in  1  one-cycle pulse; begin work for the line after vcount.
- vcount  in  10  current scanline.
- spr_wr_en  in  1  attribute write strobe.
- spr_wr_idx  in  $clog2(NUM_SPRITE)  attribute write index.
- spr_wr_data  in  32  attribute word.
- rom_addr  out  ROM_AW = 8+$clog2(SPR_W)+$clog2(SPR_H)  pattern address.
- rom_q  in  16  pattern data, valid one cycle after rom_addr.
- pix_col  out  10  line-buffer column.
- pix_data  out  16  RGB565 pixel.
- pix_wren  out  1  line-buffer write enable.
- done  out  1  line finished (level).
- overflow  out  1  more than MAX_SLOT sprites hit the current line.

## Operation
- Attribute word: [31] enable, [30] hflip, [29] vflip, [28:27] reserved (ignored), [26:18] row, [17:8] col, [7:0] frame.
- target = vcount+1, wrapping V_TOTAL-1 → 0.
- FSM IDLE → SCAN → DRAW → DONE. line_start accepted only in IDLE or DONE; ignored elsewhere.
- On accept: overflow cleared, slot count cleared. If target ≥ V_ACTIVE → DONE directly.
- SCAN: read indices 0..NUM_SPRITE-1, one per cycle. Hit = enable && target ≥ row && (target − row) < SPR_H, computed at 10 bits with no wrap. Hits are stored in index order with row_off = target − row, or SPR_H−1−that when vflip. Once MAX_SLOT slots are full, any further hit sets overflow and scanning stops.
- DRAW: slots are drawn in ascending order, so the highest index is on top. For each slot, x = 0..SPR_W-1, one address per cycle:
  - rom_addr = {frame, row_off, hflip ? SPR_W−1−x : x}.
  - Next cycle, pix_wren = (rom_q ≠ TRANSPARENT) && (col+x < H_ACTIVE), with the sum taken at 11 bits; pix_col = col+x.
  - Slots are back-to-back with no bubble.
  - Zero slots → DONE.
- DONE: done = 1 until next accepted line_start or reset.
- Attribute writes are allowed in any state. A same-index read and write in one cycle returns old data. The RAM is not reset; it initialises to zero.
- Reset: FSM → IDLE. rom_addr, pix_col, pix_data, pix_wren, done, and overflow all 0. Any in-flight line is abandoned.

## Timing
- SCAN: NUM_SPRITE+1 cycles, one extra for RAM latency; shorter on overflow.
- DRAW: n·SPR_W address cycles plus 1 drain cycle.
- done rises in the cycle after the last possible pix_wren.
- Line latency = 1 + (NUM_SPRITE+1) + n·SPR_W + 1 cycles (n = slots). Must be below 800 for the defaults.

## Structure
- Package sprite_pkg:
  - attribute struct typedef and field constants.
  - FSM state enum.
  - slot struct {col, frame, row_off, hflip}.
  - ROM address-width function.
- Sub-module sprite_attr_ram: 1R1W synchronous RAM, read-before-write.

## Test plan
- Sprite 0 = 32'h80000000, vcount=524, line_start → 16 writes at cols 0–15; rom_addr 0..15; done after 1+33+16+1 cycles.
- Sprite 0 = 32'hC0000000 (hflip) → rom_addr sequence 15..0 with pix_col 0..15. Same with vflip, target row 0 → rom_addr base 15·16 = 240.
- Nine enabled sprites on row 10, vcount=9 → exactly 8 sprites drawn (indices 0–7); overflow=1; sprite 8 never addressed.
- col=632, rom_q all non-zero → pix_wren for cols 632–639 only. rom_q = 16'h0000 → no write at that column.
- vcount=479 → done within 2 cycles, no pix_wren. line_start during DRAW is ignored.
- reset=0 mid-DRAW → next cycle all outputs 0, state IDLE; subsequent line_start runs a full line normally.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared types for the sprite line engine: attribute word layout, per-line
// slot record, FSM states and the pattern-ROM address width helper.
package sprite_pkg;

  localparam int unsigned ATTR_W        = 32;
  localparam int unsigned FRAME_W       = 8;
  localparam int unsigned COL_W         = 10;
  localparam int unsigned ROW_W         = 9;
  localparam int unsigned LINE_W        = 10;
  localparam int unsigned PIX_W         = 16;
  // Slot row offset is held at full width so sprites up to 256 rows tall fit.
  localparam int unsigned ROW_OFF_MAX_W = 8;

  // Host-visible attribute word, MSB first.
  typedef struct packed {
    logic               enable;
    logic               hflip;
    logic               vflip;
    logic [1:0]         rsvd;
    logic [ROW_W-1:0]   row;
    logic [COL_W-1:0]   col;
    logic [FRAME_W-1:0] frame;
  } attr_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DRAW,
    ST_DONE
  } state_t;

  // One sprite selected for the line being built.
  typedef struct packed {
    logic [COL_W-1:0]         col;
    logic [FRAME_W-1:0]       frame;
    logic [ROW_OFF_MAX_W-1:0] row_off;
    logic                     hflip;
  } slot_t;

  function automatic int unsigned rom_aw(input int unsigned spr_w, input int unsigned spr_h);
    return FRAME_W + $clog2(spr_w) + $clog2(spr_h);
  endfunction

endpackage

// File: rtl/sprite_line_engine_if.sv
// Host attribute-write bus.
//   spr_wr_en   attribute write strobe
//   spr_wr_idx  attribute entry index
//   spr_wr_data attribute word
// master = host side, slave = engine side.
interface sprite_line_engine_if
  import sprite_pkg::*;
#(
  parameter int unsigned NUM_SPRITE = 32
) ();

  localparam int unsigned IW = $clog2(NUM_SPRITE);

  logic              spr_wr_en;
  logic [IW-1:0]     spr_wr_idx;
  logic [ATTR_W-1:0] spr_wr_data;

  modport master (output spr_wr_en, output spr_wr_idx, output spr_wr_data);
  modport slave  (input  spr_wr_en, input  spr_wr_idx, input  spr_wr_data);

endinterface

// File: rtl/sprite_attr_ram.sv
// Sprite attribute store: 1 read / 1 write port, synchronous read, a read and
// write to the same entry in one cycle returns the old word. Not reset.
//   clk              clock
//   wr_en/idx/data   host write port
//   rd_idx           read index, data appears on rd_data next cycle
module sprite_attr_ram
  import sprite_pkg::*;
#(
  parameter  int unsigned DEPTH = 32,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_idx,
  input  attr_t         wr_data,
  input  logic [AW-1:0] rd_idx,
  output attr_t         rd_data
);

  attr_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
    rd_data <= mem[rd_idx];
  end

endmodule

// File: rtl/sprite_line_engine.sv
// Line-buffered sprite engine. On an accepted line_start it scans the
// attribute RAM for sprites crossing the next visible line, keeps up to
// MAX_SLOT of them, then streams their pattern pixels to the line buffer.
//   clk, reset      clock, synchronous active-low reset
//   line_start      pulse; build the line after vcount
//   vcount          current scanline
//   host            attribute write bus
//   rom_addr/rom_q  pattern ROM, 1-cycle read latency
//   pix_col/data/wren  line-buffer write port
//   done            line complete (level)
//   overflow        more than MAX_SLOT sprites hit this line
module sprite_line_engine
  import sprite_pkg::*;
#(
  parameter  int unsigned      NUM_SPRITE  = 32,
  parameter  int unsigned      MAX_SLOT    = 8,
  parameter  int unsigned      SPR_W       = 16,
  parameter  int unsigned      SPR_H       = 16,
  parameter  int unsigned      H_ACTIVE    = 640,
  parameter  int unsigned      V_ACTIVE    = 480,
  parameter  int unsigned      V_TOTAL     = 525,
  parameter  logic [PIX_W-1:0] TRANSPARENT = 16'h0000,
  localparam int unsigned      ROM_AW      = rom_aw(SPR_W, SPR_H)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               line_start,
  input  logic [LINE_W-1:0]  vcount,
  sprite_line_engine_if.slave host,
  output logic [ROM_AW-1:0]  rom_addr,
  input  logic [PIX_W-1:0]   rom_q,
  output logic [COL_W-1:0]   pix_col,
  output logic [PIX_W-1:0]   pix_data,
  output logic               pix_wren,
  output logic               done,
  output logic               overflow
);

  localparam int unsigned IW    = $clog2(NUM_SPRITE);
  localparam int unsigned SCW   = IW + 1;
  localparam int unsigned XW    = $clog2(SPR_W);
  localparam int unsigned RW    = $clog2(SPR_H);
  localparam int unsigned CW    = $clog2(MAX_SLOT + 1);
  localparam int unsigned SIW   = (MAX_SLOT > 1) ? $clog2(MAX_SLOT) : 1;
  localparam int unsigned SUM_W = COL_W + 1;

  state_t              state, state_nxt;
  logic [SCW-1:0]      scan_cnt, scan_nxt;
  logic [CW-1:0]       slot_cnt, slot_cnt_nxt;
  logic [CW-1:0]       draw_slot, draw_slot_nxt;
  logic [XW-1:0]       draw_x, draw_x_nxt;
  logic [LINE_W-1:0]   target, target_nxt;
  logic                overflow_nxt;
  logic                pend, pend_nxt;
  logic                col_ok, col_ok_nxt;
  logic [COL_W-1:0]    pix_col_nxt;

  attr_t               ram_q;
  slot_t               slots [MAX_SLOT];
  slot_t               new_slot;
  slot_t               cur;
  logic                slot_we;

  logic [LINE_W-1:0]   line_next;
  logic [LINE_W-1:0]   row_ext;
  logic [LINE_W-1:0]   row_diff;
  logic [RW-1:0]       row_off;
  logic                hit;
  logic [XW-1:0]       x_eff;
  logic [SUM_W-1:0]    col_sum;
  logic                unused_bits;

  sprite_attr_ram #(.DEPTH(NUM_SPRITE)) u_attr_ram (
    .clk     (clk),
    .wr_en   (host.spr_wr_en),
    .wr_idx  (host.spr_wr_idx),
    .wr_data (attr_t'(host.spr_wr_data)),
    .rd_idx  (scan_cnt[IW-1:0]),
    .rd_data (ram_q)
  );

  // Line to be built, wrapping at the end of the frame.
  assign line_next = (vcount == LINE_W'(V_TOTAL - 1)) ? '0 : vcount + LINE_W'(1);

  // Hit test on the word read last cycle; target >= row guards the subtraction.
  assign row_ext  = LINE_W'(ram_q.row);
  assign row_diff = target - row_ext;
  assign hit      = ram_q.enable && (target >= row_ext) && (row_diff < LINE_W'(SPR_H));
  assign row_off  = row_diff[RW-1:0] ^ {RW{ram_q.vflip}};
  assign new_slot = '{col:     ram_q.col,
                      frame:   ram_q.frame,
                      row_off: ROW_OFF_MAX_W'(row_off),
                      hflip:   ram_q.hflip};

  // Slot being drawn; mirrored x is the bitwise complement for power-of-two widths.
  assign cur     = slots[draw_slot[SIW-1:0]];
  assign x_eff   = draw_x ^ {XW{cur.hflip}};
  assign col_sum = SUM_W'(cur.col) + SUM_W'(draw_x);

  assign unused_bits = ^{ram_q.rsvd, cur.row_off};

  // Next-state and datapath control.
  always_comb begin
    state_nxt     = state;
    scan_nxt      = scan_cnt;
    slot_cnt_nxt  = slot_cnt;
    draw_slot_nxt = draw_slot;
    draw_x_nxt    = draw_x;
    target_nxt    = target;
    overflow_nxt  = overflow;
    pend_nxt      = 1'b0;
    col_ok_nxt    = col_ok;
    pix_col_nxt   = pix_col;
    slot_we       = 1'b0;
    rom_addr      = '0;

    case (state)
      ST_IDLE, ST_DONE: begin
        if (line_start) begin
          target_nxt    = line_next;
          overflow_nxt  = 1'b0;
          slot_cnt_nxt  = '0;
          scan_nxt      = '0;
          draw_slot_nxt = '0;
          draw_x_nxt    = '0;
          state_nxt     = (line_next >= LINE_W'(V_ACTIVE)) ? ST_DONE : ST_SCAN;
        end
      end

      // scan_cnt == k issues read k and tests the word of entry k-1.
      ST_SCAN: begin
        scan_nxt = scan_cnt + SCW'(1);
        if (scan_cnt == SCW'(NUM_SPRITE)) state_nxt = ST_DRAW;
        if ((scan_cnt != '0) && hit) begin
          if (slot_cnt == CW'(MAX_SLOT)) begin
            overflow_nxt = 1'b1;
            state_nxt    = ST_DRAW;
          end else begin
            slot_we      = 1'b1;
            slot_cnt_nxt = slot_cnt + CW'(1);
          end
        end
      end

      // draw_slot == slot_cnt is the drain cycle for the last ROM read.
      ST_DRAW: begin
        if (draw_slot == slot_cnt) begin
          state_nxt = ST_DONE;
        end else begin
          rom_addr    = {cur.frame, cur.row_off[RW-1:0], x_eff};
          pend_nxt    = 1'b1;
          col_ok_nxt  = col_sum < SUM_W'(H_ACTIVE);
          pix_col_nxt = col_sum[COL_W-1:0];
          draw_x_nxt  = draw_x + XW'(1);
          if (draw_x == XW'(SPR_W - 1)) draw_slot_nxt = draw_slot + CW'(1);
        end
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

  // State and pipeline registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_IDLE;
      scan_cnt  <= '0;
      slot_cnt  <= '0;
      draw_slot <= '0;
      draw_x    <= '0;
      target    <= '0;
      overflow  <= 1'b0;
      pend      <= 1'b0;
      col_ok    <= 1'b0;
      pix_col   <= '0;
    end else begin
      state     <= state_nxt;
      scan_cnt  <= scan_nxt;
      slot_cnt  <= slot_cnt_nxt;
      draw_slot <= draw_slot_nxt;
      draw_x    <= draw_x_nxt;
      target    <= target_nxt;
      overflow  <= overflow_nxt;
      pend      <= pend_nxt;
      col_ok    <= col_ok_nxt;
      pix_col   <= pix_col_nxt;
    end
  end

  // Slot list; contents are only meaningful below slot_cnt.
  always_ff @(posedge clk) begin
    if (slot_we) slots[slot_cnt[SIW-1:0]] <= new_slot;
  end

  // ROM data lands in the cycle after its address, so the write qualifies it directly.
  assign pix_wren = pend && col_ok && (rom_q != TRANSPARENT);
  assign pix_data = pend ? rom_q : '0;
  assign done     = (state == ST_DONE);

endmodule

// File: tb/tb_sprite_line_engine.sv
// Scoreboard bench for sprite_line_engine. The pattern ROM model returns
// address ^ 16'hF000, so every checked pixel value also identifies the ROM
// address that produced it.
module tb_sprite_line_engine;

  typedef struct packed {
    logic [9:0]  col;
    logic [15:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        line_start;
  logic [9:0]  vcount;
  logic [15:0] rom_addr;
  logic [15:0] rom_q;
  logic [9:0]  pix_col;
  logic [15:0] pix_data;
  logic        pix_wren;
  logic        done;
  logic        overflow;

  logic        clear_en;
  logic [15:0] clear_addr;

  exp_t q[$];
  exp_t mon_e;
  int   n_cmp  = 0;
  int   n_fail = 0;

  sprite_line_engine_if #(.NUM_SPRITE(32)) host_if ();

  sprite_line_engine dut (
    .clk        (clk),
    .reset      (reset),
    .line_start (line_start),
    .vcount     (vcount),
    .host       (host_if),
    .rom_addr   (rom_addr),
    .rom_q      (rom_q),
    .pix_col    (pix_col),
    .pix_data   (pix_data),
    .pix_wren   (pix_wren),
    .done       (done),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  // Pattern ROM, one cycle latency, with one optional transparent address.
  always @(posedge clk) begin
    if (clear_en && rom_addr == clear_addr) rom_q <= 16'h0000;
    else                                    rom_q <= rom_addr ^ 16'hF000;
  end

  // Monitor: every line-buffer write must match the head of the queue.
  always @(negedge clk) begin
    if (pix_wren === 1'b1) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: col=%0d data=%h, nothing expected", pix_col, pix_data);
      end else begin
        mon_e = q.pop_front();
        if (pix_col !== mon_e.col || pix_data !== mon_e.data) begin
          n_fail++;
          $display("FAIL pixel: got col=%0d data=%h, expected col=%0d data=%h",
                   pix_col, pix_data, mon_e.col, mon_e.data);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk_attr(input bit en, input bit hf, input bit vf,
                                          input int row, input int col, input int frame);
    return {en, hf, vf, 2'b00, 9'(row), 10'(col), 8'(frame)};
  endfunction

  task automatic attr_write(input int idx, input logic [31:0] data);
    @(negedge clk);
    host_if.spr_wr_en   = 1'b1;
    host_if.spr_wr_idx  = 5'(idx);
    host_if.spr_wr_data = data;
    @(negedge clk);
    host_if.spr_wr_en   = 1'b0;
  endtask

  task automatic clear_all();
    for (int i = 0; i < 32; i++) attr_write(i, 32'h0);
  endtask

  // Queue the pixels one sprite contributes; row_off is supplied already resolved.
  task automatic exp_sprite(input int col, input int frame, input int row_off, input bit hflip);
    exp_t e;
    for (int x = 0; x < 16; x++) begin
      int a;
      int c;
      a = frame * 256 + row_off * 16 + (hflip ? 15 - x : x);
      c = col + x;
      if (c < 640 && !(clear_en && a == int'(clear_addr))) begin
        e.col  = 10'(c);
        e.data = 16'(a) ^ 16'hF000;
        q.push_back(e);
      end
    end
  endtask

  // Issue line_start, count cycles until done; optional second pulse mid-line.
  task automatic run_line(input string name, input int v, input int exp_k,
                          input int exp_ovf, input int pulse_at);
    int k;
    bit seen;
    @(negedge clk);
    vcount     = 10'(v);
    line_start = 1'b1;
    k    = 0;
    seen = 1'b0;
    while (!seen && k < 1000) begin
      @(negedge clk);
      k++;
      line_start = (k == pulse_at);
      if (k == pulse_at) vcount = 10'd479;
      if (done === 1'b1) seen = 1'b1;
    end
    line_start = 1'b0;
    check({name, "_latency"}, k, exp_k);
    check({name, "_overflow"}, int'(overflow), exp_ovf);
    check({name, "_queue_left"}, q.size(), 0);
  endtask

  initial begin
    reset               = 1'b0;
    line_start          = 1'b0;
    vcount              = 10'd0;
    host_if.spr_wr_en   = 1'b0;
    host_if.spr_wr_idx  = '0;
    host_if.spr_wr_data = '0;
    clear_en            = 1'b0;
    clear_addr          = 16'h0;

    repeat (3) @(negedge clk);
    check("rst_done",     int'(done),     0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_pix_wren", int'(pix_wren), 0);
    check("rst_rom_addr", int'(rom_addr), 0);
    check("rst_pix_col",  int'(pix_col),  0);
    check("rst_pix_data", int'(pix_data), 0);
    @(negedge clk);
    reset = 1'b1;

    // Single plain sprite on row 0, line wraps 524 -> 0.
    clear_all();
    attr_write(0, 32'h8000_0000);
    exp_sprite(0, 0, 0, 1'b0);
    run_line("plain", 524, 51, 0, 0);

    // Horizontal flip: addresses 15..0 at columns 0..15.
    attr_write(0, 32'hC000_0000);
    exp_sprite(0, 0, 0, 1'b1);
    run_line("hflip", 524, 51, 0, 0);

    // Vertical flip on row 0: row_off 15, base address 240.
    attr_write(0, 32'hA000_0000);
    exp_sprite(0, 0, 15, 1'b0);
    run_line("vflip", 524, 51, 0, 0);

    // Nine sprites on row 10: first eight drawn, ninth only raises overflow.
    for (int i = 0; i < 9; i++) attr_write(i, mk_attr(1, 0, 0, 10, 20 * i, i + 1));
    for (int i = 0; i < 8; i++) exp_sprite(20 * i, i + 1, 0, 1'b0);
    run_line("ovf", 9, 140, 1, 0);

    // Right-edge clip plus one transparent pixel; a line_start mid-draw is ignored.
    clear_all();
    attr_write(3, mk_attr(1, 0, 0, 100, 632, 8'h12));
    clear_en   = 1'b1;
    clear_addr = 16'h1252;
    exp_sprite(632, 8'h12, 5, 1'b0);
    run_line("clip", 104, 51, 0, 40);
    clear_en   = 1'b0;

    // Last visible row plus one: straight to done, nothing drawn.
    run_line("blank", 479, 1, 0, 0);

    // Bottom row of the sprite still hits; one row further misses.
    exp_sprite(632, 8'h12, 15, 1'b0);
    run_line("last_row", 114, 51, 0, 0);
    run_line("no_hit", 115, 35, 0, 0);

    // Reset in the middle of drawing, then a clean line.
    clear_all();
    attr_write(0, 32'h8000_0000);
    exp_sprite(0, 0, 0, 1'b0);
    @(negedge clk);
    vcount     = 10'd524;
    line_start = 1'b1;
    @(negedge clk);
    line_start = 1'b0;
    repeat (39) @(negedge clk);
    #1;
    q.delete();
    reset = 1'b0;
    @(negedge clk);
    check("midrst_rom_addr", int'(rom_addr), 0);
    check("midrst_pix_wren", int'(pix_wren), 0);
    check("midrst_pix_col",  int'(pix_col),  0);
    check("midrst_pix_data", int'(pix_data), 0);
    check("midrst_done",     int'(done),     0);
    check("midrst_overflow", int'(overflow), 0);
    reset = 1'b1;
    exp_sprite(0, 0, 0, 1'b0);
    run_line("after_rst", 524, 51, 0, 0);

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
